// File: rtl/led_strip_pkg.sv
// Shared constants for the LED strip scope: APA102 command codes, display modes,
// frame FSM states and the per-segment colour palette.
package led_strip_pkg;
   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_SOF   = 2'b01;
   localparam logic [1:0] CMD_PIXEL = 2'b10;
   localparam logic [1:0] CMD_EOF   = 2'b11;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'd0,
      MODE_BAR   = 2'd1,
      MODE_DOT   = 2'd2,
      MODE_OFF   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SOF   = 2'd1,
      ST_PIXEL = 2'd2,
      ST_EOF   = 2'd3
   } state_t;

   // {r,g,b} enable masks indexed by segment % 4: red, green, blue, white
   localparam logic [3:0][2:0] PALETTE = {3'b111, 3'b001, 3'b010, 3'b100};
endpackage

// File: rtl/led_pixel_render.sv
// Combinational pixel colour for one segment position from a signed sample.
// Zero latency, no flow control; the caller registers the result when it issues.
module led_pixel_render
   import led_strip_pkg::*;
#(
   parameter int W       = 16,
   parameter int SEG_LEN = 75,
   parameter int IDX_W   = 7
) (
   input  logic signed [W-1:0] s,
   input  logic [IDX_W-1:0]    idx,
   input  logic [1:0]          mode,
   input  logic [1:0]          seg,
   output logic [7:0]          red,
   output logic [7:0]          green,
   output logic [7:0]          blue
);
   localparam int PROD_W = W - 1 + $clog2(SEG_LEN + 1);

   logic [W-2:0]      p;
   logic [PROD_W-1:0] prod;
   logic [IDX_W-1:0]  pos;
   logic [7:0]        bri;
   logic [7:0]        v;
   logic [2:0]        mask;

   always_comb begin
      // negative samples clamp to zero, so pos lands on 0 and bri is dark
      p    = (s > 0) ? s[W-2:0] : '0;
      prod = PROD_W'(p) * PROD_W'(SEG_LEN);
      pos  = IDX_W'(prod >> (W - 1));
      bri  = p[W-2 -: 8];
      v    = 8'h00;
      case (mode)
         MODE_LEVEL: v = bri;
         MODE_BAR:   v = ((s > 0) && (idx <= pos)) ? 8'hFF : 8'h00;
         MODE_DOT:   v = (idx == pos) ? 8'hFF : 8'h00;
         default:    v = 8'h00;
      endcase
      mask  = PALETTE[seg];
      red   = mask[2] ? v : 8'h00;
      green = mask[1] ? v : 8'h00;
      blue  = mask[0] ? v : 8'h00;
   end
endmodule

// File: rtl/led_strip_scope.sv
// APA102 frame generator: snapshots N_CH samples per frame and renders equal strip segments.
// Issues one command per cycle where the serializer is idle and no strobe is pending.
module led_strip_scope
   import led_strip_pkg::*;
#(
   parameter int W         = 16,
   parameter int N_PIXELS  = 300,
   parameter int N_CH      = 4,
   parameter int FRAME_DIV = 256
) (
   input  logic              clk_12mhz,
   input  logic              rst,
   input  logic              sample_clk,
   input  logic [N_CH*W-1:0] samples,
   input  logic [1:0]        mode,
   output logic [1:0]        apa102_cmd,
   output logic              apa102_strobe,
   input  logic              apa102_busy,
   output logic [7:0]        px_red,
   output logic [7:0]        px_green,
   output logic [7:0]        px_blue,
   output logic              frame_active,
   output logic              overrun
);
   localparam int SEG_LEN = N_PIXELS / N_CH;
   localparam int IDX_W   = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
   localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic              sample_clk_q;
   logic [DIV_W-1:0]  div_cnt;
   logic              rise;
   logic              trigger;
   logic              can_issue;
   state_t            state;
   logic [N_CH*W-1:0] snap;
   mode_t             snap_mode;
   logic [2:0]        seg;
   logic [IDX_W-1:0]  idx;
   logic signed [W-1:0] s_cur;
   logic [7:0]        r_nxt, g_nxt, b_nxt;

   assign rise      = sample_clk & ~sample_clk_q;
   assign trigger   = rise && (div_cnt == DIV_W'(FRAME_DIV - 1));
   assign can_issue = !apa102_busy && !apa102_strobe;
   assign s_cur     = snap[int'(seg) * W +: W];

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         sample_clk_q <= 1'b0;
         div_cnt      <= '0;
      end else begin
         sample_clk_q <= sample_clk;
         if (rise)
            div_cnt <= (div_cnt == DIV_W'(FRAME_DIV - 1)) ? '0 : div_cnt + 1'b1;
      end
   end

   led_pixel_render #(.W(W), .SEG_LEN(SEG_LEN), .IDX_W(IDX_W)) u_render (
      .s     (s_cur),
      .idx   (idx),
      .mode  (snap_mode),
      .seg   (seg[1:0]),
      .red   (r_nxt),
      .green (g_nxt),
      .blue  (b_nxt)
   );

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         apa102_cmd    <= CMD_NONE;
         apa102_strobe <= 1'b0;
         px_red        <= 8'h00;
         px_green      <= 8'h00;
         px_blue       <= 8'h00;
         frame_active  <= 1'b0;
         overrun       <= 1'b0;
         seg           <= '0;
         idx           <= '0;
         snap          <= '0;
         snap_mode     <= MODE_LEVEL;
      end else begin
         apa102_strobe <= 1'b0;
         if (trigger && state != ST_IDLE)
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  snap      <= samples;
                  snap_mode <= mode_t'(mode);
                  state     <= ST_SOF;
               end
            end
            ST_SOF: begin
               if (can_issue) begin
                  apa102_cmd    <= CMD_SOF;
                  apa102_strobe <= 1'b1;
                  frame_active  <= 1'b1;
                  seg           <= '0;
                  idx           <= '0;
                  state         <= ST_PIXEL;
               end
            end
            ST_PIXEL: begin
               if (can_issue) begin
                  apa102_cmd    <= CMD_PIXEL;
                  apa102_strobe <= 1'b1;
                  px_red        <= r_nxt;
                  px_green      <= g_nxt;
                  px_blue       <= b_nxt;
                  if (idx == IDX_W'(SEG_LEN - 1)) begin
                     idx <= '0;
                     if (seg == 3'(N_CH - 1))
                        state <= ST_EOF;
                     else
                        seg <= seg + 3'd1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_EOF: begin
               if (can_issue) begin
                  apa102_cmd    <= CMD_EOF;
                  apa102_strobe <= 1'b1;
                  frame_active  <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
